// File: rtl/mmio_out_fifo.sv
// rtl/mmio_out_fifo.sv - memory-mapped output FIFO behind the proc2 data bus
//
// Decodes proc2 writes into a DATA/STATUS register pair, buffers pushed words
// in a DEPTH-entry FIFO and drains them to an external sink through a
// valid/ready handshake. STATUS is read back through the registered rdata port.
//
// Ports:
//   clk        single clock, all state on posedge
//   rst        asynchronous active-high reset
//   addr       proc2 address bus (block decoded on addr[15:12])
//   dout       proc2 write data
//   w          proc2 write strobe
//   sel        combinational address hit
//   rdata      registered read data, zero when not selected
//   out_data   head-of-FIFO word
//   out_valid  FIFO non-empty
//   out_ready  sink accepts out_data at posedge when out_valid is high
//   irq_ovf    sticky overflow flag (STATUS[15])
//
// STATUS layout: {ovf, 7'b0, count[5:0], empty, full}

module mmio_out_fifo #(
  parameter logic [15:0] BASE_ADDR = 16'h1000,
  parameter int          DEPTH     = 8,
  parameter int          AW        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] dout,
  input  logic        w,
  output logic        sel,
  output logic [15:0] rdata,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        irq_ovf
);

  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rdptr;
  logic [AW-1:0] wrptr;
  logic [AW:0]   count;
  logic          ovf;

  logic          push_req;
  logic          push_acc;
  logic          push_rej;
  logic          pop;
  logic          ovf_clr;
  logic          full;
  logic          empty;
  logic [15:0]   status;

  // Offset bits between the register select and the block decode are ignored.
  logic          unused_addr;
  assign unused_addr = ^addr[11:1];

  assign sel       = (addr[15:12] == BASE_ADDR[15:12]);
  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign out_valid = !empty;
  assign out_data  = mem[rdptr];
  assign irq_ovf   = ovf;
  assign status    = {ovf, 7'b0, 6'(count), empty, full};

  assign pop      = out_valid && out_ready;
  assign push_req = sel && w && !addr[0];
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_acc = push_req && (!full || pop);
  assign push_rej = push_req && !push_acc;
  assign ovf_clr  = sel && w && addr[0] && dout[15];

  // Storage has no reset; only pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wrptr] <= dout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdptr <= '0;
      wrptr <= '0;
      count <= '0;
      ovf   <= 1'b0;
      rdata <= 16'h0000;
    end else begin
      if (push_acc) begin
        wrptr <= wrptr + 1'b1;
      end
      if (pop) begin
        rdptr <= rdptr + 1'b1;
      end
      if (push_acc && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push_acc) begin
        count <= count - 1'b1;
      end
      // A rejected push in the same cycle as a clear keeps the flag set.
      if (push_rej) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
      rdata <= sel ? (addr[0] ? status : out_data) : 16'h0000;
    end
  end

endmodule
